// File: rtl/sdram_resp.sv
// sdram_resp: single-chip SDR SDRAM responder with CL/BL, open-row tracking.
// `SDRAM_RESP_CHECK_EN` compiles in the protocol checker driving err_flag/err_code.
module sdram_resp #(
  parameter int ROW_USE_W = 2,
  parameter int COL_W     = 9,
  parameter int TRCD      = 2,
  parameter int TRP       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cke,
  input  logic [3:0]  sdram_cmd,
  input  logic [1:0]  sdram_bank,
  input  logic [12:0] sdram_addr,
  input  logic [1:0]  sdram_dqm,
  input  logic [15:0] sdram_dq_i,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  output logic        err_flag,
  output logic [2:0]  err_code
);
  localparam int AW = 2 + ROW_USE_W + COL_W;
  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_USE_W-1:0] row_t;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} rstate_e;
  typedef enum logic {W_IDLE, W_DATA} wstate_e;

  logic [15:0] mem [0:(1<<AW)-1];

  logic sel, c_act, c_rd, c_wr, c_pre, c_aref, c_mrs, c_bst;
  assign sel    = cke && !sdram_cmd[3];
  assign c_act  = sel && sdram_cmd[2:0] == 3'b011;
  assign c_rd   = sel && sdram_cmd[2:0] == 3'b101;
  assign c_wr   = sel && sdram_cmd[2:0] == 3'b100;
  assign c_pre  = sel && sdram_cmd[2:0] == 3'b010;
  assign c_aref = sel && sdram_cmd[2:0] == 3'b001;
  assign c_mrs  = sel && sdram_cmd[2:0] == 3'b000;
  assign c_bst  = sel && sdram_cmd[2:0] == 3'b110;

  col_t c_col;
  assign c_col = sdram_addr[COL_W-1:0];

  logic unused_addr;
  assign unused_addr = ^sdram_addr;

  logic [3:0] open_q, open_d, pre_v;
  logic [3:0][ROW_USE_W-1:0] row_q, row_d;
  logic cl3_q, wbs_q;
  logic [2:0] bl_q;

  rstate_e rs_q, rs_d;
  logic lat_q, lat_d, r_full_q, r_full_d, r_ap_q, r_ap_d;
  logic [1:0] r_bank_q, r_bank_d;
  row_t r_row_q, r_row_d;
  col_t r_col_q, r_col_d;
  logic [2:0] r_left_q, r_left_d;

  wstate_e ws_q, ws_d;
  logic w_full_q, w_full_d, w_ap_q, w_ap_d;
  logic [1:0] w_bank_q, w_bank_d;
  row_t w_row_q, w_row_d;
  col_t w_col_q, w_col_d;
  logic [2:0] w_left_q, w_left_d;

  logic s1_v_q, s2_v_q, oe_q, src_v;
  logic [15:0] s1_d_q, s2_d_q, dq_o_q, src_d;

  col_t bmask;
  logic bl_full;
  always_comb begin
    case (bl_q)
      3'b001:  bmask = col_t'(1);
      3'b010:  bmask = col_t'(3);
      3'b011:  bmask = col_t'(7);
      3'b111:  bmask = '1;
      default: bmask = '0;
    endcase
  end
  assign bl_full = bl_q == 3'b111;

  // Sequential wrap inside the BL-aligned block; all-ones mask = full page.
  function automatic col_t wrap_inc(col_t c, col_t m);
    return (c & ~m) | ((c + col_t'(1)) & m);
  endfunction

  logic issue, rd_ap, r_stop, r_more;
  logic [AW-1:0] ra;
  assign r_more = r_full_q || r_left_q != 3'd0;
  assign r_stop = c_bst || c_wr ||
                  (c_pre && (sdram_addr[10] || sdram_bank == r_bank_q));

  always_comb begin
    rs_d = rs_q; lat_d = lat_q;
    r_bank_d = r_bank_q; r_row_d = r_row_q; r_col_d = r_col_q;
    r_left_d = r_left_q; r_full_d = r_full_q; r_ap_d = r_ap_q;
    issue = 1'b0; rd_ap = 1'b0;
    ra = {r_bank_q, r_row_q, r_col_q};
    if (c_rd) begin
      issue = 1'b1;
      ra = {sdram_bank, row_q[sdram_bank], c_col};
      rs_d = R_LAT; lat_d = cl3_q;
      r_bank_d = sdram_bank; r_row_d = row_q[sdram_bank];
      r_col_d = wrap_inc(c_col, bmask);
      r_left_d = bmask[2:0]; r_full_d = bl_full;
      r_ap_d = sdram_addr[10];
    end else if (r_stop) begin
      rs_d = R_IDLE;
    end else if (cke) begin
      if (rs_q != R_IDLE && r_more) begin
        issue = 1'b1;
        r_col_d = wrap_inc(r_col_q, bmask);
        if (!r_full_q) r_left_d = r_left_q - 3'd1;
      end
      unique case (rs_q)
        R_LAT: begin
          if (!lat_q) rs_d = R_DATA;
          else lat_d = 1'b0;
        end
        R_DATA: begin
          if (!r_more) begin
            rs_d = R_IDLE;
            rd_ap = r_ap_q;
          end
        end
        default: ;
      endcase
    end
  end

  logic we, wr_ap, w_stop;
  logic [1:0] wr_ap_bank;
  logic [AW-1:0] wa;
  assign w_stop = c_bst || c_rd ||
                  (c_pre && (sdram_addr[10] || sdram_bank == w_bank_q));

  always_comb begin
    ws_d = ws_q;
    w_bank_d = w_bank_q; w_row_d = w_row_q; w_col_d = w_col_q;
    w_left_d = w_left_q; w_full_d = w_full_q; w_ap_d = w_ap_q;
    we = 1'b0; wr_ap = 1'b0; wr_ap_bank = w_bank_q;
    wa = {w_bank_q, w_row_q, w_col_q};
    if (c_wr) begin
      we = 1'b1;
      wa = {sdram_bank, row_q[sdram_bank], c_col};
      w_bank_d = sdram_bank; w_row_d = row_q[sdram_bank];
      w_col_d = wrap_inc(c_col, bmask);
      w_ap_d = sdram_addr[10];
      if (wbs_q || bmask == '0) begin
        ws_d = W_IDLE;
        wr_ap = sdram_addr[10];
        wr_ap_bank = sdram_bank;
      end else begin
        ws_d = W_DATA;
        w_left_d = bmask[2:0];
        w_full_d = bl_full;
      end
    end else if (w_stop) begin
      ws_d = W_IDLE;
    end else if (cke && ws_q == W_DATA) begin
      we = 1'b1;
      w_col_d = wrap_inc(w_col_q, bmask);
      if (!w_full_q) begin
        w_left_d = w_left_q - 3'd1;
        if (w_left_q == 3'd1) begin
          ws_d = W_IDLE;
          wr_ap = w_ap_q;
        end
      end
    end
  end

  always_comb begin
    open_d = open_q; row_d = row_q; pre_v = '0;
    if (c_pre) pre_v = sdram_addr[10] ? 4'hF : (4'b1 << sdram_bank);
    if (rd_ap) pre_v[r_bank_q] = 1'b1;
    if (wr_ap) pre_v[wr_ap_bank] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (pre_v[i]) begin
        open_d[i] = 1'b0;
        row_d[i] = '0;
      end
    end
    if (c_act) begin
      open_d[sdram_bank] = 1'b1;
      row_d[sdram_bank] = sdram_addr[ROW_USE_W-1:0];
    end
  end

  assign src_v = cl3_q ? s2_v_q : s1_v_q;
  assign src_d = cl3_q ? s2_d_q : s1_d_q;

  // Array and latency-pipe data carry no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we && !sdram_dqm[0]) mem[wa][7:0] <= sdram_dq_i[7:0];
    if (we && !sdram_dqm[1]) mem[wa][15:8] <= sdram_dq_i[15:8];
    if (issue) s1_d_q <= mem[ra];
    if (cke) s2_d_q <= s1_d_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0; row_q <= '0;
      cl3_q <= 1'b1; bl_q <= 3'b000; wbs_q <= 1'b0;
      rs_q <= R_IDLE; lat_q <= 1'b0;
      r_bank_q <= '0; r_row_q <= '0; r_col_q <= '0;
      r_left_q <= '0; r_full_q <= 1'b0; r_ap_q <= 1'b0;
      ws_q <= W_IDLE;
      w_bank_q <= '0; w_row_q <= '0; w_col_q <= '0;
      w_left_q <= '0; w_full_q <= 1'b0; w_ap_q <= 1'b0;
      s1_v_q <= 1'b0; s2_v_q <= 1'b0;
      oe_q <= 1'b0; dq_o_q <= '0;
    end else if (cke) begin
      open_q <= open_d; row_q <= row_d;
      if (c_mrs) begin
        bl_q <= sdram_addr[2:0];
        wbs_q <= sdram_addr[9];
        if (sdram_addr[6:4] == 3'b010) cl3_q <= 1'b0;
        if (sdram_addr[6:4] == 3'b011) cl3_q <= 1'b1;
      end
      rs_q <= rs_d; lat_q <= lat_d;
      r_bank_q <= r_bank_d; r_row_q <= r_row_d; r_col_q <= r_col_d;
      r_left_q <= r_left_d; r_full_q <= r_full_d; r_ap_q <= r_ap_d;
      ws_q <= ws_d;
      w_bank_q <= w_bank_d; w_row_q <= w_row_d; w_col_q <= w_col_d;
      w_left_q <= w_left_d; w_full_q <= w_full_d; w_ap_q <= w_ap_d;
      s1_v_q <= issue;
      s2_v_q <= s1_v_q && !c_wr;
      oe_q <= src_v && !c_wr;
      if (src_v) dq_o_q <= src_d;
    end
  end

  assign sdram_dq_o  = dq_o_q;
  assign sdram_dq_oe = oe_q;

`ifdef SDRAM_RESP_CHECK_EN
  localparam logic [3:0] TRCD4 = 4'(TRCD);
  localparam logic [3:0] TRP4  = 4'(TRP);
  logic [3:0][3:0] act_cnt_q, pre_cnt_q;
  logic err_q;
  logic [2:0] code_q, vcode;
  logic rw;
  assign rw = c_rd || c_wr;

  always_comb begin
    vcode = 3'd0;
    unique case (1'b1)
      c_act && open_q[sdram_bank]: vcode = 3'd1;
      c_act && !open_q[sdram_bank] && pre_cnt_q[sdram_bank] < TRP4:
        vcode = 3'd4;
      rw && !open_q[sdram_bank]: vcode = 3'd2;
      rw && open_q[sdram_bank] && act_cnt_q[sdram_bank] < TRCD4:
        vcode = 3'd3;
      c_aref && |open_q: vcode = 3'd5;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_cnt_q <= '1; pre_cnt_q <= '1;
      err_q <= 1'b0; code_q <= '0;
    end else if (cke) begin
      for (int i = 0; i < 4; i++) begin
        if (c_act && sdram_bank == 2'(i)) act_cnt_q[i] <= 4'd1;
        else if (act_cnt_q[i] != 4'hF) act_cnt_q[i] <= act_cnt_q[i] + 4'd1;
        if (pre_v[i]) pre_cnt_q[i] <= 4'd1;
        else if (pre_cnt_q[i] != 4'hF) pre_cnt_q[i] <= pre_cnt_q[i] + 4'd1;
      end
      if (!err_q && vcode != 3'd0) begin
        err_q <= 1'b1;
        code_q <= vcode;
      end
    end
  end

  assign err_flag = err_q;
  assign err_code = code_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{4'(TRCD), 4'(TRP), c_aref};
  assign err_flag = 1'b0;
  assign err_code = 3'd0;
`endif
endmodule

// File: tb/tb_sdram_resp.sv
// tb_sdram_resp: directed bursts, wrap, DQM, cke freeze, checker and reset.
// Checker expectations depend on whether SDRAM_RESP_CHECK_EN is defined.
module tb_sdram_resp;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] MRS = 4'b0000;
  localparam logic [3:0] BST = 4'b0110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke = 1'b1;
  logic [3:0]  sdram_cmd = NOP;
  logic [1:0]  sdram_bank = '0;
  logic [12:0] sdram_addr = '0;
  logic [1:0]  sdram_dqm = '0;
  logic [15:0] sdram_dq_i = '0;
  logic [15:0] sdram_dq_o;
  logic        sdram_dq_oe;
  logic        err_flag;
  logic [2:0]  err_code;

  int n_chk = 0;
  int n_fail = 0;
  int cnt;
  logic [15:0] t2 [4] = '{16'hCCCC, 16'hDDDD, 16'hAAAA, 16'hBBBB};
  logic [15:0] t3 [5] = '{16'h1510, 16'h1511, 16'h1000, 16'h1001, 16'h0003};
  logic [12:0] c3 [5] = '{13'd510, 13'd511, 13'd0, 13'd1, 13'd2};

  sdram_resp dut (
    .clk(clk), .rst_n(rst_n), .cke(cke),
    .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank),
    .sdram_addr(sdram_addr), .sdram_dqm(sdram_dqm),
    .sdram_dq_i(sdram_dq_i), .sdram_dq_o(sdram_dq_o),
    .sdram_dq_oe(sdram_dq_oe), .err_flag(err_flag),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] b,
                     input logic [12:0] a, input logic [15:0] d);
    sdram_cmd = c; sdram_bank = b; sdram_addr = a; sdram_dq_i = d;
    @(negedge clk);
    sdram_cmd = NOP;
  endtask

  task automatic nop(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd1(input string tag, input logic [12:0] col,
                     input int cl, input logic [15:0] exp);
    cmd(RD, 2'd0, col, 16'h0);
    repeat (cl - 2) @(negedge clk);
    chk({tag, "_pre"}, 32'(sdram_dq_oe), 32'd0);
    @(negedge clk);
    chk({tag, "_oe"}, 32'(sdram_dq_oe), 32'd1);
    chk(tag, 32'(sdram_dq_o), 32'(exp));
    @(negedge clk);
    chk({tag, "_drop"}, 32'(sdram_dq_oe), 32'd0);
  endtask

  initial begin
    nop(2);
    chk("rst_dq", 32'(sdram_dq_o), 32'd0);
    chk("rst_oe", 32'(sdram_dq_oe), 32'd0);
    chk("rst_err", 32'(err_flag), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    nop(1);

    // full page CL3: write 1..10, BST, reread with BST 10 cycles later
    cmd(MRS, 2'd0, 13'h037, 16'h0); nop(2);
    cmd(ACT, 2'd0, 13'h0, 16'h0); nop(2);
    cmd(WR, 2'd0, 13'd0, 16'd1);
    for (int k = 2; k <= 10; k++) begin
      sdram_dq_i = 16'(k);
      @(negedge clk);
    end
    cmd(BST, 2'd0, 13'h0, 16'd11); nop(2);
    cmd(PRE, 2'd0, 13'h0, 16'h0); nop(2);
    cmd(ACT, 2'd0, 13'h0, 16'h0); nop(2);
    cmd(RD, 2'd0, 13'd0, 16'h0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("fp_oe%0d", i), 32'(sdram_dq_oe),
          32'(i >= 2 && i <= 11));
      if (i >= 2 && i <= 11)
        chk($sformatf("fp_dq%0d", i), 32'(sdram_dq_o), 32'(i - 1));
      if (sdram_dq_oe) cnt++;
      sdram_cmd = (i == 9) ? BST : NOP;
      @(negedge clk);
    end
    sdram_cmd = NOP;
    chk("fp_len", 32'(cnt), 32'd10);

    // CL2 BL4: write col6 A..D, read col4 -> C,D,A,B
    cmd(MRS, 2'd0, 13'h022, 16'h0); nop(2);
    cmd(WR, 2'd0, 13'd6, 16'hAAAA);
    sdram_dq_i = 16'hBBBB; @(negedge clk);
    sdram_dq_i = 16'hCCCC; @(negedge clk);
    sdram_dq_i = 16'hDDDD; @(negedge clk);
    nop(2);
    cmd(RD, 2'd0, 13'd4, 16'h0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bl4_oe%0d", i), 32'(sdram_dq_oe),
          32'(i >= 1 && i <= 4));
      if (i >= 1 && i <= 4)
        chk($sformatf("bl4_dq%0d", i), 32'(sdram_dq_o), 32'(t2[i-1]));
      @(negedge clk);
    end

    // full page write across the page end, then BL1 CL2 readback
    cmd(MRS, 2'd0, 13'h037, 16'h0); nop(2);
    cmd(WR, 2'd0, 13'd510, 16'h1510);
    sdram_dq_i = 16'h1511; @(negedge clk);
    sdram_dq_i = 16'h1000; @(negedge clk);
    sdram_dq_i = 16'h1001; @(negedge clk);
    cmd(BST, 2'd0, 13'h0, 16'hEEEE); nop(2);
    cmd(MRS, 2'd0, 13'h020, 16'h0); nop(2);
    for (int i = 0; i < 5; i++)
      rd1($sformatf("wrap%0d", i), c3[i], 2, t3[i]);

    // byte mask: low byte kept
    cmd(WR, 2'd0, 13'd20, 16'hFFFF); nop(1);
    sdram_dqm = 2'b01;
    cmd(WR, 2'd0, 13'd20, 16'h1234);
    sdram_dqm = 2'b00;
    nop(1);
    rd1("dqm", 13'd20, 2, 16'h12FF);

    // cke low freezes the latency pipe
    cmd(RD, 2'd0, 13'd20, 16'h0);
    cke = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("cke_hold%0d", i), 32'(sdram_dq_oe), 32'd0);
    end
    cke = 1'b1;
    @(negedge clk);
    chk("cke_oe", 32'(sdram_dq_oe), 32'd1);
    chk("cke_dq", 32'(sdram_dq_o), 32'h12FF);
    @(negedge clk);
    chk("cke_drop", 32'(sdram_dq_oe), 32'd0);

    // protocol checker
    chk("chk_clean", 32'(err_flag), 32'd0);
    cmd(RD, 2'd1, 13'd0, 16'h0); nop(3);
    cmd(ACT, 2'd0, 13'h0, 16'h0); nop(2);
`ifdef SDRAM_RESP_CHECK_EN
    chk("chk_flag", 32'(err_flag), 32'd1);
    chk("chk_code", 32'(err_code), 32'd2);
`else
    chk("chk_flag", 32'(err_flag), 32'd0);
    chk("chk_code", 32'(err_code), 32'd0);
`endif

    // reset during a read burst, then defaults and retained data
    cmd(MRS, 2'd0, 13'h037, 16'h0); nop(2);
    cmd(RD, 2'd0, 13'd0, 16'h0);
    nop(2);
    chk("rr_oe", 32'(sdram_dq_oe), 32'd1);
    chk("rr_dq", 32'(sdram_dq_o), 32'h1000);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_oe_rst", 32'(sdram_dq_oe), 32'd0);
    chk("rr_dq_rst", 32'(sdram_dq_o), 32'd0);
    chk("rr_err_rst", 32'(err_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nop(1);
    cmd(ACT, 2'd0, 13'h0, 16'h0); nop(2);
    rd1("post_rst", 13'd20, 3, 16'h12FF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
